fft_iter_engine: RTL and testbench
==================================

Name: fft_iter_engine

Overview:
- Parametrised, in-place, iterative radix-2 decimation-in-time FFT/IFFT engine.
- Successor to the fixed 64-point parallel-array butterfly. Adds:
  - generic N, data width and twiddle width
  - streaming valid/ready load and unload
  - signed fixed-point arithmetic with rounding
  - forward/inverse mode and optional per-stage scaling
- Sits between the sample front-end and the spectral post-processing.
- Computes one butterfly per cycle on an internal N-entry complex register array.

Parameters:
- N_PTS, 64, transform length; power of two, 8..1024.
- LOG2_N, 6, log2(N_PTS); must be consistent with N_PTS.
- DW, 16, data width per real/imag component; signed Q1.(DW-1).
- TW, 16, twiddle width per component; signed Q1.(TW-1).

Ports:
- clk  in  1  single clock; all logic on posedge.
- rst  in  1  synchronous, active-low reset.
- in_valid  in  1  input sample valid.
- in_ready  out  1  engine accepts a sample; high in IDLE and LOAD.
- in_re  in  DW  input real part, signed.
- in_im  in  DW  input imag part, signed.
- inverse  in  1  sampled with the first input sample; 1 = IFFT (conjugate twiddles).
- scale_en  in  1  sampled with the first input sample; 1 = arithmetic shift right by 1 after every stage.
- out_valid  out  1  output bin valid.
- out_ready  in  1  downstream accepts a bin.
- out_re  out  DW  output bin real part.
- out_im  out  DW  output bin imag part.
- out_last  out  1  high with bin N_PTS-1.
- busy  out  1  high in LOAD, CALC and UNLOAD.

Behaviour:
- Reset (rst=0 at a posedge):
  - state=IDLE; all pointers and counters 0.
  - Array contents are don't-care.
  - out_valid=0, out_last=0, busy=0, out_re=out_im=0; in_ready=1 from the first cycle after reset.
- Reset mid-operation aborts immediately. Partial data is discarded and no further outputs are produced.
- FSM states: IDLE, LOAD, CALC, UNLOAD.
- IDLE -> LOAD on the first in_valid&in_ready handshake.
  - inverse and scale_en are latched on that handshake.
  - That sample is written to array[bitrev(0)] = array[0].
- LOAD: handshake i (0..N_PTS-1) writes array[bitrev_LOG2_N(i)]. After handshake N_PTS-1, go to CALC.
- CALC:
  - Stage s = 0..LOG2_N-1, butterfly b = 0..N_PTS/2-1, one per cycle.
  - half = 2^s, pos = b & (half-1), top = ((b>>s)<<(s+1)) + pos, bot = top + half, k = pos << (LOG2_N-1-s).
  - t = W_k * x[bot]; x[top] <= x[top] + t; x[bot] <= x[top] - t. Both writes happen in the same cycle.
  - After the last butterfly of the last stage, go to UNLOAD.
  - CALC lasts exactly LOG2_N*N_PTS/2 cycles.
- UNLOAD:
  - out_valid=1; out_re/out_im = array[j] in natural order, j = 0..N_PTS-1.
  - j advances only on out_valid&out_ready. Outputs hold stable while stalled.
  - out_last=1 when j = N_PTS-1. After that handshake, go to IDLE.
- in_ready=0 in CALC and UNLOAD. in_valid in those states is ignored with no side effect.
- A new frame may begin in the cycle after the final UNLOAD handshake.
- Twiddles:
  - Wr_k = round(cos(2*pi*k/N_PTS) * (2^(TW-1)-1)).
  - Ws_k = round(sin(2*pi*k/N_PTS) * (2^(TW-1)-1)).
  - Forward: W_k = Wr_k - j*Ws_k. Inverse: W_k = Wr_k + j*Ws_k.
- Complex multiply:
  - Full-precision products of DW+TW bits.
  - Each real/imag sum gets +2^(TW-2), then an arithmetic shift right by TW-1, then truncation to DW+1 bits.
- Add/sub:
  - Computed at DW+1 bits.
  - scale_en=1: result >>> 1 (floor), then take DW bits. This cannot overflow.
  - scale_en=0: take the low DW bits (two's-complement wrap; no saturation).
- Total frame latency, first input handshake to first out_valid, is N_PTS + LOG2_N*N_PTS/2 cycles.

Decomposition:
- Shared package fft_pkg:
  - state enum typedef.
  - Complex struct typedef {re, im} parametrised by width.
  - bitrev function.
  - Rounding-constant function.
- Sub-module fft_twiddle_rom:
  - Combinational; k (LOG2_N-1 bits) -> {Wr_k, Ws_k}.
  - Table generated at elaboration from N_PTS and TW.
  - The engine applies the inverse sign.

Test Plan:
- Impulse: N_PTS=8, x[0]=0x4000, others 0, forward, scale_en=0 -> all 8 bins re=0x4000, im=0x0000; out_last only on bin 7.
- Impulse scaled: same stimulus, scale_en=1 -> all bins re=0x0800, im=0.
- DC: N_PTS=8, all samples re=0x0800, forward, scale_en=0 -> bin0 re=0x4000 ±1 LSB; bins 1..7 exactly 0.
- Round trip:
  - N_PTS=64, random |x|<0x0400.
  - Forward with scale_en=0, then feed the result back with inverse=1, scale_en=1.
  - Result: original samples within ±2 LSB.
- Timing and backpressure:
  - N_PTS=8; first out_valid exactly 8+12=20 cycles after the first input handshake.
  - Hold out_ready=0 for 5 cycles at bin 3 -> out_re/out_im/out_last stable; bin order unchanged; in_ready stays 0 throughout.
- Reset mid-CALC:
  - Drive rst=0 for one cycle in cycle 5 of CALC.
  - Next cycle: state IDLE, busy=0, out_valid=0, in_ready=1.
  - The next full frame produces correct results.

Source files
------------

// File: rtl/fft_pkg.sv
// Shared types and helpers for the iterative FFT engine.
//   state_t   : engine FSM states
//   bitrev    : reverse the low 'bits' bits of an index (load address order)
//   rnd_const : round-half-up constant added before the twiddle product shift
package fft_pkg;

  typedef enum logic [1:0] {IDLE, LOAD, CALC, UNLOAD} state_t;

  // Widest index supported (N_PTS up to 1024).
  localparam int MAX_LOG2 = 10;

  // Shift-in form keeps every bit select constant after unrolling.
  function automatic logic [MAX_LOG2-1:0] bitrev(input logic [MAX_LOG2-1:0] v,
                                                 input int bits);
    logic [MAX_LOG2-1:0] r;
    r = '0;
    for (int i = 0; i < MAX_LOG2; i++)
      if (i < bits) r = {r[MAX_LOG2-2:0], v[i]};
    return r;
  endfunction

  // Half an LSB of a Q1.(tw-1) product, i.e. 2^(tw-2).
  function automatic longint rnd_const(input int tw);
    return longint'(1) <<< (tw - 2);
  endfunction

endpackage

// File: rtl/fft_twiddle_rom.sv
// Twiddle table: k -> {round(cos(2*pi*k/N)*A), round(sin(2*pi*k/N)*A)},
// A = 2^(TW-1)-1. Combinational, built at elaboration. The caller applies
// the forward/inverse sign to the sine term.
//   k  : twiddle index, 0..N_PTS/2-1
//   wr : cosine term, signed Q1.(TW-1)
//   ws : sine term, signed Q1.(TW-1)
module fft_twiddle_rom #(
  parameter int N_PTS  = 64,
  parameter int LOG2_N = 6,
  parameter int TW     = 16
) (
  input  logic        [LOG2_N-2:0] k,
  output logic signed [TW-1:0]     wr,
  output logic signed [TW-1:0]     ws
);
  localparam int  HALF = N_PTS / 2;
  localparam real PI   = 3.141592653589793;
  localparam real AMP  = real'((2 ** (TW - 1)) - 1);

  // Round half away from zero.
  function automatic logic signed [TW-1:0] tw_round(input real x);
    int r;
    r = (x >= 0.0) ? $rtoi(x + 0.5) : $rtoi(x - 0.5);
    return TW'(r);
  endfunction

  logic signed [TW-1:0] wr_tab [HALF];
  logic signed [TW-1:0] ws_tab [HALF];

  for (genvar g = 0; g < HALF; g++) begin : g_tab
    assign wr_tab[g] = tw_round($cos(2.0 * PI * real'(g) / real'(N_PTS)) * AMP);
    assign ws_tab[g] = tw_round($sin(2.0 * PI * real'(g) / real'(N_PTS)) * AMP);
  end

  assign wr = wr_tab[k];
  assign ws = ws_tab[k];

endmodule

// File: rtl/fft_iter_engine.sv
// In-place iterative radix-2 DIT FFT/IFFT, one butterfly per cycle.
// Samples stream in (bit-reversed write addressing), LOG2_N stages of
// N_PTS/2 butterflies run over an internal register array, then bins
// stream out in natural order.
//   clk, rst                     : clock, synchronous active-low reset
//   in_valid/in_ready/in_re/in_im: sample load handshake
//   inverse, scale_en            : mode, latched with the first sample
//   out_valid/out_ready          : bin unload handshake
//   out_re/out_im/out_last       : bin data, last marks bin N_PTS-1
//   busy                         : frame in progress
module fft_iter_engine
  import fft_pkg::*;
#(
  parameter int N_PTS  = 64,
  parameter int LOG2_N = 6,
  parameter int DW     = 16,
  parameter int TW     = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_re,
  input  logic [DW-1:0] in_im,
  input  logic          inverse,
  input  logic          scale_en,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_re,
  output logic [DW-1:0] out_im,
  output logic          out_last,
  output logic          busy
);
  localparam int PW = DW + TW + 1;
  localparam logic signed [PW-1:0] RND = PW'(rnd_const(TW));

  typedef struct packed {
    logic signed [DW-1:0] re;
    logic signed [DW-1:0] im;
  } cplx_t;

  state_t            state;
  cplx_t             arr [N_PTS];
  logic [LOG2_N-1:0] ld_cnt, ld_idx, oj, oj_nxt;
  logic [LOG2_N-2:0] bfly, k;
  logic [3:0]        stage;
  logic              inv_q, scl_q;

  logic [LOG2_N-1:0]    b_ext, half, pos, top, bot;
  cplx_t                xt, xb, nt, nb;
  logic signed [TW-1:0] wr, ws, wi;
  logic signed [PW-1:0] br, bi, wre, wie, sre, sim;
  logic signed [DW:0]   tre, tim, ar, ai, dr, di;

  assign in_ready = (state == IDLE) || (state == LOAD);
  assign busy     = (state != IDLE);
  assign ld_idx   = LOG2_N'(bitrev(MAX_LOG2'(ld_cnt), LOG2_N));
  assign oj_nxt   = oj + 1'b1;

  // Butterfly addressing for (stage, bfly).
  always_comb begin
    b_ext = {1'b0, bfly};
    half  = LOG2_N'(1) << stage;
    pos   = b_ext & (half - 1'b1);
    top   = ((b_ext >> stage) << (stage + 4'd1)) | pos;
    bot   = top | half;
    k     = (LOG2_N-1)'(pos << (LOG2_N - 1 - stage));
  end

  fft_twiddle_rom #(.N_PTS(N_PTS), .LOG2_N(LOG2_N), .TW(TW)) u_rom (
    .k (k),
    .wr(wr),
    .ws(ws)
  );

  // DW+1 bit add/sub result -> DW bits: halve (floor) or wrap.
  function automatic logic signed [DW-1:0] fin(input logic signed [DW:0] v,
                                               input logic sc);
    return sc ? v[DW:1] : v[DW-1:0];
  endfunction

  always_comb begin
    xt  = arr[top];
    xb  = arr[bot];
    wi  = inv_q ? ws : -ws;
    br  = PW'($signed(xb.re));
    bi  = PW'($signed(xb.im));
    wre = PW'(wr);
    wie = PW'(wi);
    sre = br * wre - bi * wie + RND;
    sim = br * wie + bi * wre + RND;
    tre = (DW+1)'(sre >>> (TW - 1));
    tim = (DW+1)'(sim >>> (TW - 1));
    ar  = (DW+1)'($signed(xt.re)) + tre;
    ai  = (DW+1)'($signed(xt.im)) + tim;
    dr  = (DW+1)'($signed(xt.re)) - tre;
    di  = (DW+1)'($signed(xt.im)) - tim;
    nt  = '{re: fin(ar, scl_q), im: fin(ai, scl_q)};
    nb  = '{re: fin(dr, scl_q), im: fin(di, scl_q)};
  end

  // Sample array: no reset, contents are rewritten every frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      if (in_valid && in_ready)
        arr[ld_idx] <= '{re: in_re, im: in_im};
      else if (state == CALC) begin
        arr[top] <= nt;
        arr[bot] <= nb;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      ld_cnt    <= '0;
      stage     <= '0;
      bfly      <= '0;
      oj        <= '0;
      inv_q     <= 1'b0;
      scl_q     <= 1'b0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_re    <= '0;
      out_im    <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          inv_q  <= inverse;
          scl_q  <= scale_en;
          ld_cnt <= LOG2_N'(1);
          state  <= LOAD;
        end
        LOAD: if (in_valid) begin
          if (ld_cnt == LOG2_N'(N_PTS - 1)) begin
            ld_cnt <= '0;
            stage  <= '0;
            bfly   <= '0;
            state  <= CALC;
          end else
            ld_cnt <= ld_cnt + 1'b1;
        end
        CALC: begin
          if (&bfly) begin
            bfly <= '0;
            if (stage == 4'(LOG2_N - 1)) begin
              // The final butterfly touches N/2-1 and N-1, never entry 0,
              // so bin 0 can be registered in this same cycle.
              stage     <= '0;
              oj        <= '0;
              out_valid <= 1'b1;
              out_last  <= 1'b0;
              out_re    <= arr[0].re;
              out_im    <= arr[0].im;
              state     <= UNLOAD;
            end else
              stage <= stage + 4'd1;
          end else
            bfly <= bfly + 1'b1;
        end
        UNLOAD: if (out_ready) begin
          if (oj == LOG2_N'(N_PTS - 1)) begin
            oj        <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            state     <= IDLE;
          end else begin
            oj       <= oj_nxt;
            out_re   <= arr[oj_nxt].re;
            out_im   <= arr[oj_nxt].im;
            out_last <= (oj_nxt == LOG2_N'(N_PTS - 1));
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fft_iter_engine.sv
// Bench for fft_iter_engine: an 8-point instance (index 0) for the
// directed patterns, timing, backpressure and reset, and a 64-point
// instance (index 1) for the forward/inverse round trip.
module tb_fft_iter_engine;

  logic clk = 1'b0;
  logic rst;
  logic        in_valid [2], inverse [2], scale_en [2], out_ready [2];
  logic        in_ready [2], out_valid [2], out_last [2], busy [2];
  logic [15:0] in_re [2], in_im [2], out_re [2], out_im [2];

  always #5 clk = ~clk;

  fft_iter_engine #(.N_PTS(8), .LOG2_N(3), .DW(16), .TW(16)) dut8 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .in_re(in_re[0]), .in_im(in_im[0]),
    .inverse(inverse[0]), .scale_en(scale_en[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .out_re(out_re[0]), .out_im(out_im[0]),
    .out_last(out_last[0]), .busy(busy[0])
  );

  fft_iter_engine #(.N_PTS(64), .LOG2_N(6), .DW(16), .TW(16)) dut64 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .in_re(in_re[1]), .in_im(in_im[1]),
    .inverse(inverse[1]), .scale_en(scale_en[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .out_re(out_re[1]), .out_im(out_im[1]),
    .out_last(out_last[1]), .busy(busy[1])
  );

  typedef struct {
    int re;
    int im;
    int tol;
    bit last;
  } exp_t;

  exp_t sb[$];
  int   n_chk = 0, n_fail = 0;
  int   cyc = 0, hs_cyc = 0;
  int   src_re [64], src_im [64], cap_re [64], cap_im [64];
  int   org_re [64], org_im [64];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int npts(input bit d);
    return d ? 64 : 8;
  endfunction

  function automatic int lat(input bit d);
    return d ? 64 + 6 * 32 : 8 + 3 * 4;
  endfunction

  function automatic int rnd(input real x);
    return (x >= 0.0) ? $rtoi(x + 0.5) : $rtoi(x - 0.5);
  endfunction

  task automatic chk(input string tag, input int obs, input int exp_v, input int tol = 0);
    n_chk++;
    if (obs > exp_v + tol || obs < exp_v - tol) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (tol %0d) @cyc %0d", tag, obs, exp_v, tol, cyc);
    end
  endtask

  task automatic clr_src();
    for (int i = 0; i < 64; i++) begin
      src_re[i] = 0;
      src_im[i] = 0;
    end
  endtask

  task automatic push(input int re, input int im, input int tol, input bit last);
    exp_t e;
    e.re = re; e.im = im; e.tol = tol; e.last = last;
    sb.push_back(e);
  endtask

  // Mode bits carry the requested value only on the first sample and the
  // opposite value afterwards, so only the latched copy can be honoured.
  task automatic drive_frame(input bit d, input bit inv, input bit sc);
    int w;
    for (int i = 0; i < npts(d); i++) begin
      @(negedge clk);
      in_valid[d] = 1'b1;
      in_re[d]    = 16'(src_re[i]);
      in_im[d]    = 16'(src_im[i]);
      inverse[d]  = (i == 0) ? inv : ~inv;
      scale_en[d] = (i == 0) ? sc : ~sc;
      w = 0;
      while (!in_ready[d] && w < 2000) begin
        @(negedge clk);
        w++;
      end
      if (!in_ready[d]) begin
        chk("in_ready_wait", int'(in_ready[d]), 1);
        break;
      end
      if (i == 0) hs_cyc = cyc;
      @(posedge clk);
    end
    @(negedge clk);
    in_valid[d] = 1'b0;
    inverse[d]  = 1'b0;
    scale_en[d] = 1'b0;
  endtask

  task automatic collect(input bit d, input bit do_chk, input int stall_j);
    int   w, n;
    exp_t e;
    n = npts(d);
    out_ready[d] = 1'b1;
    for (int j = 0; j < n; j++) begin
      @(negedge clk);
      w = 0;
      while (!out_valid[d] && w < 2000) begin
        @(negedge clk);
        w++;
      end
      if (!out_valid[d]) begin
        chk("out_valid_wait", int'(out_valid[d]), 1);
        break;
      end
      if (j == 0) chk("latency", cyc - hs_cyc, lat(d));
      cap_re[j] = int'($signed(out_re[d]));
      cap_im[j] = int'($signed(out_im[d]));
      if (do_chk && sb.size() == 0) begin
        chk("sb_empty", sb.size(), 1);
        break;
      end
      if (do_chk) e = sb[0];
      if (j == stall_j && do_chk) begin
        out_ready[d] = 1'b0;
        repeat (5) begin
          @(negedge clk);
          chk("stall_re", int'($signed(out_re[d])), e.re, e.tol);
          chk("stall_im", int'($signed(out_im[d])), e.im, e.tol);
          chk("stall_last", int'(out_last[d]), int'(e.last));
          chk("stall_valid", int'(out_valid[d]), 1);
          chk("stall_in_ready", int'(in_ready[d]), 0);
        end
        out_ready[d] = 1'b1;
      end
      if (do_chk) begin
        void'(sb.pop_front());
        chk($sformatf("bin%0d_re", j), int'($signed(out_re[d])), e.re, e.tol);
        chk($sformatf("bin%0d_im", j), int'($signed(out_im[d])), e.im, e.tol);
        chk($sformatf("bin%0d_last", j), int'(out_last[d]), int'(e.last));
        chk("unload_in_ready", int'(in_ready[d]), 0);
      end
      @(posedge clk);
    end
    @(negedge clk);
    out_ready[d] = 1'b0;
    chk("out_valid_end", int'(out_valid[d]), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, cyc %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    for (int d = 0; d < 2; d++) begin
      in_valid[d] = 1'b0; inverse[d] = 1'b0; scale_en[d] = 1'b0;
      out_ready[d] = 1'b0; in_re[d] = '0; in_im[d] = '0;
    end
    rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", int'(in_ready[0]), 1);
    chk("rst_busy", int'(busy[0]), 0);
    chk("rst_out_valid", int'(out_valid[0]), 0);
    chk("rst_out_last", int'(out_last[0]), 0);
    chk("rst_out_re", int'(out_re[0]), 0);
    chk("rst_out_im", int'(out_im[0]), 0);
    chk("rst_in_ready64", int'(in_ready[1]), 1);
    rst = 1'b1;

    // Impulse at x[0], unscaled: flat spectrum of 0x4000.
    clr_src();
    src_re[0] = 16384;
    for (int j = 0; j < 8; j++) push(16384, 0, 0, j == 7);
    drive_frame(0, 0, 0);
    chk("load_busy", int'(busy[0]), 1);
    collect(0, 1, -1);

    // Same impulse with per-stage halving: 0x4000 / 8.
    for (int j = 0; j < 8; j++) push(2048, 0, 0, j == 7);
    drive_frame(0, 0, 1);
    collect(0, 1, -1);

    // DC: all energy in bin 0.
    clr_src();
    for (int i = 0; i < 8; i++) src_re[i] = 2048;
    for (int j = 0; j < 8; j++) push(j == 0 ? 16384 : 0, 0, j == 0 ? 1 : 0, j == 7);
    drive_frame(0, 0, 0);
    collect(0, 1, -1);

    // Impulse at x[1]: X[k] = 0x4000 * exp(-j*2*pi*k/8), all bins distinct.
    // Junk in_valid during CALC must be ignored; stall 5 cycles at bin 3.
    clr_src();
    src_re[1] = 16384;
    for (int j = 0; j < 8; j++) begin
      real a;
      a = 2.0 * 3.141592653589793 * real'(j) / 8.0;
      push(rnd(16384.0 * $cos(a)), rnd(-16384.0 * $sin(a)), 2, j == 7);
    end
    drive_frame(0, 0, 0);
    in_valid[0] = 1'b1;
    in_re[0] = 16'h7fff;
    in_im[0] = 16'h7fff;
    repeat (6) begin
      @(negedge clk);
      chk("calc_in_ready", int'(in_ready[0]), 0);
    end
    in_valid[0] = 1'b0;
    collect(0, 1, 3);

    // Abort in CALC cycle 5, then a clean frame must still be correct.
    for (int i = 0; i < 8; i++) begin
      src_re[i] = int'($urandom_range(0, 2000)) - 1000;
      src_im[i] = int'($urandom_range(0, 2000)) - 1000;
    end
    drive_frame(0, 0, 0);
    repeat (4) @(negedge clk);
    chk("calc_busy", int'(busy[0]), 1);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    chk("abort_busy", int'(busy[0]), 0);
    chk("abort_out_valid", int'(out_valid[0]), 0);
    chk("abort_in_ready", int'(in_ready[0]), 1);
    repeat (30) begin
      @(negedge clk);
      chk("abort_quiet", int'(out_valid[0]), 0);
    end
    clr_src();
    src_re[0] = 16384;
    for (int j = 0; j < 8; j++) push(16384, 0, 0, j == 7);
    drive_frame(0, 0, 0);
    collect(0, 1, -1);

    // 64-point round trip: forward unscaled, inverse scaled returns x.
    for (int i = 0; i < 64; i++) begin
      org_re[i] = int'($urandom_range(0, 1022)) - 511;
      org_im[i] = int'($urandom_range(0, 1022)) - 511;
      src_re[i] = org_re[i];
      src_im[i] = org_im[i];
    end
    drive_frame(1, 0, 0);
    collect(1, 0, -1);
    for (int i = 0; i < 64; i++) begin
      src_re[i] = cap_re[i];
      src_im[i] = cap_im[i];
      push(org_re[i], org_im[i], 2, i == 63);
    end
    drive_frame(1, 1, 1);
    collect(1, 1, -1);

    chk("sb_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
